// File: rtl/mips_arb_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states, bus bundle, defaults.
// Bus fields are sized by ARB_ADDR_W/ARB_DATA_W; the arbiter's ADDR_W/DATA_W
// must not exceed these.
package mips_arb_pkg;

  localparam int ARB_ADDR_W    = 32;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_MAX_BURST = 8;

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_HALT = 2'd1,
    S_DBG  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  read;
    logic                  write;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_bus_t;

  localparam int MEM_BUS_W = $bits(mem_bus_t);

  // Counter width for a burst limit; a limit of 1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_mem_port_mux.sv
// Combinational 2:1 RAM request mux: debug bus when selected, else CPU bus.
// When the CPU side is selected but frozen, its write strobe is masked so a
// held write cannot commit a second time.
module mips_mem_port_mux
  import mips_arb_pkg::*;
(
  input  logic                 i_sel_dbg,
  input  logic                 i_mask_write,
  input  logic [MEM_BUS_W-1:0] i_cpu_bus,
  input  logic [MEM_BUS_W-1:0] i_dbg_bus,
  output logic [MEM_BUS_W-1:0] o_mem_bus
);

  mem_bus_t w_cpu;
  mem_bus_t w_dbg;
  mem_bus_t w_out;

  assign w_cpu = i_cpu_bus;
  assign w_dbg = i_dbg_bus;

  // Pick the owner; a frozen CPU keeps address/read visible but never writes.
  always_comb begin
    w_out = w_cpu;
    if (i_sel_dbg) begin
      w_out = w_dbg;
    end else if (i_mask_write) begin
      w_out.write = 1'b0;
    end
  end

  assign o_mem_bus = w_out;

endmodule

// File: rtl/mips_data_port_arbiter.sv
// Arbitrates the single data RAM port between the CPU and a debug/dump port.
// Debug gets the port two edges after requesting (one freeze cycle first);
// ownership is bounded to MAX_BURST cycles while the CPU is active.
module mips_data_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_active,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_clk_enable,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic              dbg_read,
  input  logic              dbg_write,
  input  logic [DATA_W-1:0] dbg_writedata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int              CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  logic             r_cooldown;
  logic             w_cooldown_nxt;
  logic             r_cpu_clk_enable;
  logic             r_dbg_gnt;

  mem_bus_t         w_cpu_bus;
  mem_bus_t         w_dbg_bus;
  mem_bus_t         w_mem_bus;

  // State, burst counter, cooldown and the Moore outputs all update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_CPU;
      r_burst_cnt      <= '0;
      r_cooldown       <= 1'b0;
      r_cpu_clk_enable <= 1'b1;
      r_dbg_gnt        <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_burst_cnt      <= w_burst_cnt_nxt;
      r_cooldown       <= w_cooldown_nxt;
      r_cpu_clk_enable <= (w_state_nxt == S_CPU);
      r_dbg_gnt        <= (w_state_nxt == S_DBG);
    end
  end

  // Next-state: freeze for one cycle, then grant; a burst-limit exit forces
  // one cooldown pass through S_CPU so the CPU is guaranteed progress.
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_cooldown_nxt  = r_cooldown;
    case (r_state)
      S_CPU: begin
        w_cooldown_nxt  = 1'b0;
        w_burst_cnt_nxt = '0;
        if (dbg_req && !r_cooldown) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        w_burst_cnt_nxt = '0;
        w_state_nxt     = dbg_req ? S_DBG : S_CPU;
      end
      S_DBG: begin
        if (!dbg_req) begin
          w_state_nxt     = S_CPU;
          w_burst_cnt_nxt = '0;
        end else if (cpu_active && (r_burst_cnt == LAST)) begin
          w_state_nxt     = S_CPU;
          w_burst_cnt_nxt = '0;
          w_cooldown_nxt  = 1'b1;
        end else if (r_burst_cnt != LAST) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_CPU;
        w_burst_cnt_nxt = '0;
      end
    endcase
  end

  assign w_cpu_bus = '{addr:  ARB_ADDR_W'(cpu_address),
                       read:  cpu_read,
                       write: cpu_write,
                       wdata: ARB_DATA_W'(cpu_writedata)};
  assign w_dbg_bus = '{addr:  ARB_ADDR_W'(dbg_address),
                       read:  dbg_read,
                       write: dbg_write,
                       wdata: ARB_DATA_W'(dbg_writedata)};

  mips_mem_port_mux u_mux (
    .i_sel_dbg    (r_state == S_DBG),
    .i_mask_write (r_state == S_HALT),
    .i_cpu_bus    (w_cpu_bus),
    .i_dbg_bus    (w_dbg_bus),
    .o_mem_bus    (w_mem_bus)
  );

  assign mem_address    = w_mem_bus.addr[ADDR_W-1:0];
  assign mem_read       = w_mem_bus.read;
  assign mem_write      = w_mem_bus.write;
  assign mem_writedata  = w_mem_bus.wdata[DATA_W-1:0];

  assign cpu_readdata   = mem_readdata;
  assign dbg_readdata   = r_dbg_gnt ? mem_readdata : '0;
  assign cpu_clk_enable = r_cpu_clk_enable;
  assign dbg_gnt        = r_dbg_gnt;

endmodule

// File: tb/tb_mips_data_port_arbiter.sv
// Bench for mips_data_port_arbiter: word RAM model, per-scenario tasks,
// expected {dbg_gnt, cpu_clk_enable} / data queued at drive time and popped
// when the DUT output is sampled on the falling edge.
module tb_mips_data_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_active = 1'b1;
  logic [AW-1:0] cpu_address = '0;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [DW-1:0] cpu_writedata = '0;
  logic [DW-1:0] cpu_readdata;
  logic          cpu_clk_enable;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_address = '0;
  logic          dbg_read = 1'b0;
  logic          dbg_write = 1'b0;
  logic [DW-1:0] dbg_writedata = '0;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_readdata;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  int n_checks = 0;
  int n_fail   = 0;
  int aaaa_writes = 0;

  logic [1:0]  exp_q[$];    // {dbg_gnt, cpu_clk_enable}
  logic [31:0] exp_d_q[$];  // data values

  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  mips_data_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .cpu_active(cpu_active),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_clk_enable(cpu_clk_enable), .dbg_req(dbg_req),
    .dbg_address(dbg_address), .dbg_read(dbg_read), .dbg_write(dbg_write),
    .dbg_writedata(dbg_writedata), .dbg_gnt(dbg_gnt),
    .dbg_readdata(dbg_readdata), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  assign mem_readdata = ram[mem_address[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    ram[0] <= 32'h12345678;
  end

  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_address[9:2]] <= mem_writedata;
      if (mem_writedata == 32'hAAAA0000) aaaa_writes++;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    cpu_address = 32'hBFC00000;
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_clk_enable !== 1'b1) begin n_fail++; $display("FAIL reset_cen got=%b exp=1", cpu_clk_enable); end
    n_checks++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", dbg_gnt); end
    n_checks++; if (mem_address !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_addr got=%h exp=bfc00000", mem_address); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({dbg_gnt, cpu_clk_enable} !== 2'b01) begin n_fail++; $display("FAIL reset_idle got=%b exp=01", {dbg_gnt, cpu_clk_enable}); end
  endtask

  task automatic test_halted_read();
    logic [1:0]  e;
    logic [31:0] d;
    cpu_active = 1'b0; cpu_address = 32'h100; cpu_read = 1'b0;
    dbg_req = 1'b1; dbg_read = 1'b1; dbg_address = 32'h0;
    #1;
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL hr_nogrant_read got=%b exp=0", mem_read); end
    n_checks++; if (dbg_readdata !== 32'h0) begin n_fail++; $display("FAIL hr_nogrant_rdata got=%h exp=0", dbg_readdata); end
    exp_q.push_back(2'b00); exp_d_q.push_back(32'h0);
    exp_q.push_back(2'b10); exp_d_q.push_back(32'h12345678);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(2'b10); exp_d_q.push_back(32'h12345678);
    end
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      e = exp_q.pop_front(); d = exp_d_q.pop_front();
      n_checks++; if ({dbg_gnt, cpu_clk_enable} !== e) begin n_fail++; $display("FAIL hr_seq[%0d] got=%b exp=%b", i, {dbg_gnt, cpu_clk_enable}, e); end
      n_checks++; if (dbg_readdata !== d) begin n_fail++; $display("FAIL hr_rdata[%0d] got=%h exp=%h", i, dbg_readdata, d); end
    end
    // Count is saturated at MAX_BURST-1: raising cpu_active forces an exit now.
    cpu_active = 1'b1;
    exp_q.push_back(2'b01);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if ({dbg_gnt, cpu_clk_enable} !== e) begin n_fail++; $display("FAIL hr_sat_exit got=%b exp=%b", {dbg_gnt, cpu_clk_enable}, e); end
    dbg_req = 1'b0; dbg_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [1:0] e;
    int gnt_cycles = 0;
    cpu_active = 1'b1; dbg_req = 1'b1;
    exp_q.push_back(2'b00);
    for (int i = 0; i < MB; i++) exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    exp_q.push_back(2'b00); exp_q.push_back(2'b10);
    for (int i = 0; i < MB + 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (i <= MB && dbg_gnt === 1'b1) gnt_cycles++;
      n_checks++; if ({dbg_gnt, cpu_clk_enable} !== e) begin n_fail++; $display("FAIL burst_seq[%0d] got=%b exp=%b", i, {dbg_gnt, cpu_clk_enable}, e); end
    end
    n_checks++; if (gnt_cycles !== MB) begin n_fail++; $display("FAIL burst_len got=%0d exp=%0d", gnt_cycles, MB); end
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({dbg_gnt, cpu_clk_enable} !== 2'b01) begin n_fail++; $display("FAIL burst_release got=%b exp=01", {dbg_gnt, cpu_clk_enable}); end
  endtask

  task automatic test_cpu_write_masked();
    int base;
    logic [31:0] d;
    base = aaaa_writes;
    cpu_active = 1'b1;
    cpu_address = 32'h10; cpu_write = 1'b1; cpu_writedata = 32'hAAAA0000;
    dbg_req = 1'b1; dbg_address = 32'h10; dbg_writedata = 32'h5555; dbg_write = 1'b1;
    #1;
    n_checks++; if (mem_writedata !== 32'hAAAA0000 || mem_write !== 1'b1) begin n_fail++; $display("FAIL wr_cpu_owns got=%b/%h exp=1/aaaa0000", mem_write, mem_writedata); end
    @(negedge clk);  // CPU write committed, now S_HALT
    n_checks++; if (cpu_clk_enable !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL wr_halt_mask got=cen%b/we%b exp=0/0", cpu_clk_enable, mem_write); end
    n_checks++; if (aaaa_writes - base !== 1) begin n_fail++; $display("FAIL wr_cpu_once_a got=%0d exp=1", aaaa_writes - base); end
    @(negedge clk);  // S_DBG
    n_checks++; if (dbg_gnt !== 1'b1 || mem_writedata !== 32'h5555) begin n_fail++; $display("FAIL wr_dbg_owns got=%b/%h exp=1/5555", dbg_gnt, mem_writedata); end
    // Drop the request with the write still up: it commits since state is S_DBG.
    dbg_req = 1'b0; cpu_write = 1'b0;
    exp_d_q.push_back(32'h5555);
    @(negedge clk);
    d = exp_d_q.pop_front();
    n_checks++; if (ram[4] !== d) begin n_fail++; $display("FAIL wr_ram10 got=%h exp=%h", ram[4], d); end
    n_checks++; if (aaaa_writes - base !== 1) begin n_fail++; $display("FAIL wr_cpu_once_b got=%0d exp=1", aaaa_writes - base); end
    n_checks++; if ({dbg_gnt, cpu_clk_enable} !== 2'b01) begin n_fail++; $display("FAIL wr_release got=%b exp=01", {dbg_gnt, cpu_clk_enable}); end
    dbg_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pulse();
    logic [1:0] e;
    int lost = 0;
    int gnts = 0;
    cpu_active = 1'b1; cpu_address = 32'h100; cpu_read = 1'b0;
    dbg_req = 1'b1; dbg_read = 1'b1; dbg_address = 32'h0;
    exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (cpu_clk_enable === 1'b0) lost++;
      if (dbg_gnt === 1'b1) gnts++;
      n_checks++; if ({dbg_gnt, cpu_clk_enable} !== e) begin n_fail++; $display("FAIL pulse_seq[%0d] got=%b exp=%b", i, {dbg_gnt, cpu_clk_enable}, e); end
      if (i == 0) begin
        n_checks++; if (mem_read !== 1'b0 || mem_address !== 32'h100) begin n_fail++; $display("FAIL pulse_halt_bus got=%b/%h exp=0/00000100", mem_read, mem_address); end
        n_checks++; if (dbg_readdata !== 32'h0) begin n_fail++; $display("FAIL pulse_rdata got=%h exp=0", dbg_readdata); end
        dbg_req = 1'b0;
      end
    end
    n_checks++; if (lost !== 1) begin n_fail++; $display("FAIL pulse_lost got=%0d exp=1", lost); end
    n_checks++; if (gnts !== 0) begin n_fail++; $display("FAIL pulse_gnt got=%0d exp=0", gnts); end
    dbg_read = 1'b0;
  endtask

  task automatic test_async_reset();
    cpu_active = 1'b0; cpu_address = 32'h200;
    dbg_req = 1'b1; dbg_address = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL ar_granted got=%b exp=1", dbg_gnt); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (dbg_gnt !== 1'b0 || cpu_clk_enable !== 1'b1) begin n_fail++; $display("FAIL ar_immediate got=%b exp=01", {dbg_gnt, cpu_clk_enable}); end
    n_checks++; if (mem_address !== 32'h200) begin n_fail++; $display("FAIL ar_addr got=%h exp=00000200", mem_address); end
    @(negedge clk);
    reset = 1'b1; dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({dbg_gnt, cpu_clk_enable} !== 2'b01) begin n_fail++; $display("FAIL ar_after got=%b exp=01", {dbg_gnt, cpu_clk_enable}); end
  endtask

  initial begin
    test_reset();
    test_halted_read();
    test_burst();
    test_cpu_write_masked();
    test_pulse();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
